// File: rtl/wb_j1_cpu_core_p.sv
// J1-style stack CPU: FETCH/EXEC/MEM sequencer, 2 cycles per insn at zero wait, 3 for memory ops.
// Fetch and data cycles hold their request until ack; halt waits for an instruction boundary.
// Optional J1_CPU_MUL_EN: ALU op 14 becomes T*N and {rsp,dsp} moves to op 0 with insn[4]=1.
module wb_j1_cpu_core_p #(
    parameter int DATA_W     = 32,
    parameter int PC_W       = 14,
    parameter int DSTK_DEPTH = 32,
    parameter int RSTK_DEPTH = 32,
    parameter int CPU_NUM    = 0,
    parameter int AUTOSTART  = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [3:0]        cpu_num,
    output logic              inst_cyc_o,
    output logic [PC_W-1:0]   inst_pc_o,
    input  logic [DATA_W-1:0] inst_i,
    input  logic              inst_ack_i,
    output logic              cyc_o,
    output logic              we_o,
    output logic [DATA_W-1:0] adr_o,
    output logic [DATA_W-1:0] dat_o,
    input  logic [DATA_W-1:0] dat_i,
    input  logic              ack_i,
    output logic              io_rd_o,
    output logic              io_wr_o,
    output logic [3:0]        io_adr_o,
    output logic [7:0]        io_dat_o,
    input  logic [7:0]        io_dat_i,
    input  logic              start_i,
    input  logic [PC_W-1:0]   start_adr_i,
    input  logic              halt_i,
    output logic              running_o,
    output logic [1:0]        fault_o
);

    localparam int DSP_W = $clog2(DSTK_DEPTH);
    localparam int RSP_W = $clog2(RSTK_DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_MEM   = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    localparam logic [DATA_W-1:0] ONES = '1;
    localparam logic [DATA_W-1:0] ZERO = '0;

    logic [2:0]        state;
    logic [PC_W-1:0]   pc;
    logic [DSP_W-1:0]  dsp;
    logic [RSP_W-1:0]  rsp;
    logic [DATA_W-1:0] tos;
    logic [DATA_W-1:0] insn;
    logic              halt_pend;

    logic [DATA_W-1:0] dstk [DSTK_DEPTH];
    logic [DATA_W-1:0] rstk [RSTK_DEPTH];

    logic [DATA_W-1:0] nos;
    logic [DATA_W-1:0] tor;
    assign nos = dstk[dsp];
    assign tor = rstk[rsp];

    // Instruction decode
    logic            is_lit, is_jmp, is_zbr, is_call, is_alu;
    logic [3:0]      alu_op;
    logic            r_to_pc, t_to_n, t_to_r, n_to_m;
    logic [1:0]      rd, dd;
    logic [PC_W-1:0] target;

    assign is_lit  = insn[DATA_W-1];
    assign is_jmp  = !is_lit && (insn[DATA_W-2:DATA_W-3] == 2'b00);
    assign is_zbr  = !is_lit && (insn[DATA_W-2:DATA_W-3] == 2'b01);
    assign is_call = !is_lit && (insn[DATA_W-2:DATA_W-3] == 2'b10);
    assign is_alu  = !is_lit && (insn[DATA_W-2:DATA_W-3] == 2'b11);
    assign alu_op  = insn[11:8];
    assign r_to_pc = insn[12];
    assign t_to_n  = insn[7];
    assign t_to_r  = insn[6];
    assign n_to_m  = insn[5];
    assign rd      = insn[3:2];
    assign dd      = insn[1:0];
    assign target  = insn[PC_W-1:0];

    logic unused_insn;
    assign unused_insn = ^insn;

    logic mem_acc, io_sel;
    assign mem_acc = is_alu && ((alu_op == 4'd12) || n_to_m);
    assign io_sel  = (tos[DATA_W-1 -: 4] == 4'hF);

    logic [PC_W-1:0]   pc_inc;
    logic [DATA_W-1:0] pc_inc_ext;
    assign pc_inc     = pc + {{(PC_W-1){1'b0}}, 1'b1};
    assign pc_inc_ext = {{(DATA_W-PC_W){1'b0}}, pc_inc};

    // Stack pointer deltas and range check
    logic [1:0] d_delta, r_delta;
    always_comb begin
        d_delta = 2'b00;
        r_delta = 2'b00;
        if (is_lit) begin
            d_delta = 2'b01;
        end else if (is_zbr) begin
            d_delta = 2'b11;
        end else if (is_call) begin
            r_delta = 2'b01;
        end else if (is_alu) begin
            d_delta = dd;
            r_delta = rd;
        end
    end

    logic [DSP_W+1:0] dsp_sum;
    logic [RSP_W+1:0] rsp_sum;
    logic [DSP_W-1:0] dsp_nxt;
    logic [RSP_W-1:0] rsp_nxt;
    logic             d_fault, r_fault;

    assign dsp_sum = {2'b00, dsp} + {{DSP_W{d_delta[1]}}, d_delta};
    assign rsp_sum = {2'b00, rsp} + {{RSP_W{r_delta[1]}}, r_delta};
    assign dsp_nxt = dsp_sum[DSP_W-1:0];
    assign rsp_nxt = rsp_sum[RSP_W-1:0];
    // Underflow wraps negative and overflow reaches DEPTH: both set bit [W].
    assign d_fault = dsp_sum[DSP_W+1] | dsp_sum[DSP_W];
    assign r_fault = rsp_sum[RSP_W+1] | rsp_sum[RSP_W];

    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] stk_depths;
    logic [DATA_W-1:0] alu_res;

    assign mem_rdata  = (state == S_MEM) ? dat_i : {{(DATA_W-8){1'b0}}, io_dat_i};
    assign stk_depths = DATA_W'({rsp, dsp});

    always_comb begin
        alu_res = tos;
        case (alu_op)
            4'd0: begin
                alu_res = tos;
`ifdef J1_CPU_MUL_EN
                if (insn[4]) alu_res = stk_depths;
`endif
            end
            4'd1:  alu_res = nos;
            4'd2:  alu_res = tos + nos;
            4'd3:  alu_res = tos & nos;
            4'd4:  alu_res = tos | nos;
            4'd5:  alu_res = tos ^ nos;
            4'd6:  alu_res = ~tos;
            4'd7:  alu_res = (nos == tos) ? ONES : ZERO;
            4'd8:  alu_res = ($signed(nos) < $signed(tos)) ? ONES : ZERO;
            4'd9:  alu_res = nos >> tos;
            4'd10: alu_res = tos - {{(DATA_W-1){1'b0}}, 1'b1};
            4'd11: alu_res = tor;
            4'd12: alu_res = mem_rdata;
            4'd13: alu_res = nos << tos;
            4'd14: begin
`ifdef J1_CPU_MUL_EN
                alu_res = tos * nos;
`else
                alu_res = stk_depths;
`endif
            end
            4'd15: alu_res = (nos < tos) ? ONES : ZERO;
            default: alu_res = tos;
        endcase
    end

    logic [DATA_W-1:0] t_nxt;
    logic [PC_W-1:0]   pc_nxt;
    always_comb begin
        t_nxt  = tos;
        pc_nxt = pc_inc;
        if (is_lit) begin
            t_nxt = {1'b0, insn[DATA_W-2:0]};
        end else if (is_jmp) begin
            pc_nxt = target;
        end else if (is_zbr) begin
            t_nxt = nos;
            if (tos == ZERO) pc_nxt = target;
        end else if (is_call) begin
            pc_nxt = target;
        end else begin
            t_nxt = alu_res;
            if (r_to_pc) pc_nxt = tor[PC_W-1:0];
        end
    end

    logic              dstk_we, rstk_we;
    logic [DATA_W-1:0] rstk_dat;
    assign dstk_we  = is_lit || (is_alu && t_to_n);
    assign rstk_we  = is_call || (is_alu && t_to_r);
    assign rstk_dat = is_call ? pc_inc_ext : tos;

    logic exec_commit, commit, halt_req;
    assign exec_commit = (state == S_EXEC) && !d_fault && !r_fault && !(mem_acc && !io_sel);
    assign commit      = exec_commit || ((state == S_MEM) && ack_i);
    assign halt_req    = halt_i || halt_pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= (AUTOSTART != 0) ? S_FETCH : S_IDLE;
            pc        <= '0;
            dsp       <= '0;
            rsp       <= '0;
            tos       <= '0;
            insn      <= '0;
            fault_o   <= 2'b00;
            halt_pend <= 1'b0;
        end else begin
            if (running_o && halt_i) halt_pend <= 1'b1;
            if (commit) begin
                pc  <= pc_nxt;
                tos <= t_nxt;
                dsp <= dsp_nxt;
                rsp <= rsp_nxt;
            end
            case (state)
                S_IDLE, S_FAULT: begin
                    if (start_i) begin
                        pc        <= start_adr_i;
                        dsp       <= '0;
                        rsp       <= '0;
                        fault_o   <= 2'b00;
                        halt_pend <= 1'b0;
                        state     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (inst_ack_i) begin
                        insn  <= inst_i;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (d_fault || r_fault) begin
                        fault_o   <= {r_fault, d_fault};
                        halt_pend <= 1'b0;
                        state     <= S_FAULT;
                    end else if (mem_acc && !io_sel) begin
                        state <= S_MEM;
                    end else begin
                        state <= halt_req ? S_IDLE : S_FETCH;
                        if (halt_req) halt_pend <= 1'b0;
                    end
                end
                S_MEM: begin
                    if (ack_i) begin
                        state <= halt_req ? S_IDLE : S_FETCH;
                        if (halt_req) halt_pend <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Stack RAMs carry no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (!rst && commit && dstk_we) dstk[dsp_nxt] <= tos;
        if (!rst && commit && rstk_we) rstk[rsp_nxt] <= rstk_dat;
    end

    assign cpu_num    = 4'(CPU_NUM);
    assign running_o  = (state == S_FETCH) || (state == S_EXEC) || (state == S_MEM);
    assign inst_cyc_o = (state == S_FETCH);
    assign inst_pc_o  = pc;
    assign cyc_o      = (state == S_MEM);
    assign we_o       = (state == S_MEM) && n_to_m;
    assign adr_o      = (state == S_MEM) ? tos : ZERO;
    assign dat_o      = (state == S_MEM) ? nos : ZERO;
    assign io_rd_o    = exec_commit && (alu_op == 4'd12) && is_alu && io_sel;
    assign io_wr_o    = exec_commit && n_to_m && is_alu && io_sel;
    assign io_adr_o   = tos[3:0];
    assign io_dat_o   = nos[7:0];

endmodule

// File: tb/tb_wb_j1_cpu_core_p.sv
// Directed bench for wb_j1_cpu_core_p: small ROM and wait-state data memory model.
module tb_wb_j1_cpu_core_p;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  cpu_num;
    logic        inst_cyc_o;
    logic [13:0] inst_pc_o;
    logic [31:0] inst_i;
    logic        inst_ack_i;
    logic        cyc_o, we_o;
    logic [31:0] adr_o, dat_o, dat_i;
    logic        ack_i;
    logic        io_rd_o, io_wr_o;
    logic [3:0]  io_adr_o;
    logic [7:0]  io_dat_o, io_dat_i;
    logic        start_i;
    logic [13:0] start_adr_i;
    logic        halt_i;
    logic        running_o;
    logic [1:0]  fault_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    logic [31:0] rom [128];
    logic [31:0] dmem [16];
    int data_lat = 3;
    int dcnt = 0;

    assign inst_ack_i = inst_cyc_o;
    assign inst_i     = rom[inst_pc_o[6:0]];
    assign ack_i      = cyc_o && (dcnt == data_lat);
    assign dat_i      = dmem[adr_o[3:0]];

    always @(posedge clk) begin
        if (cyc_o && !ack_i) dcnt <= dcnt + 1;
        else dcnt <= 0;
        if (cyc_o && ack_i && we_o) dmem[adr_o[3:0]] <= dat_o;
    end

    wb_j1_cpu_core_p #(
        .DATA_W(32), .PC_W(14), .DSTK_DEPTH(4), .RSTK_DEPTH(4), .CPU_NUM(3), .AUTOSTART(0)
    ) dut (
        .clk(clk), .rst(rst), .cpu_num(cpu_num),
        .inst_cyc_o(inst_cyc_o), .inst_pc_o(inst_pc_o), .inst_i(inst_i), .inst_ack_i(inst_ack_i),
        .cyc_o(cyc_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i),
        .io_rd_o(io_rd_o), .io_wr_o(io_wr_o), .io_adr_o(io_adr_o), .io_dat_o(io_dat_o),
        .io_dat_i(io_dat_i), .start_i(start_i), .start_adr_i(start_adr_i), .halt_i(halt_i),
        .running_o(running_o), .fault_o(fault_o)
    );

    function automatic logic [31:0] f_lit(input logic [31:0] v);
        return 32'h8000_0000 | v;
    endfunction
    function automatic logic [31:0] f_jmp(input logic [31:0] a);
        return 32'h0000_0000 | a;
    endfunction
    function automatic logic [31:0] f_zbr(input logic [31:0] a);
        return 32'h2000_0000 | a;
    endfunction
    function automatic logic [31:0] f_call(input logic [31:0] a);
        return 32'h4000_0000 | a;
    endfunction
    function automatic logic [31:0] f_alu(input int op, input int r2pc, input int n2m,
                                          input int rd, input int dd);
        return 32'h6000_0000 | (r2pc << 12) | (op << 8) | (n2m << 5) | (rd << 2) | dd;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_at(input logic [13:0] a);
        start_adr_i = a;
        start_i = 1'b1;
        step(1);
        start_i = 1'b0;
    endtask

    task automatic halt_to_idle(input string tag);
        halt_i = 1'b1;
        for (int i = 0; i < 20 && running_o; i++) step(1);
        halt_i = 1'b0;
        check(tag, 32'(running_o), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int nrd, ncyc, nhi;
        for (int i = 0; i < 128; i++) rom[i] = f_jmp(i);
        rom[7'h10] = f_lit(5);          rom[7'h11] = f_lit(7);
        rom[7'h12] = f_alu(2, 0, 0, 0, 3);
        rom[7'h20] = f_lit(32'h1234);   rom[7'h21] = f_lit(32'h100);
        rom[7'h22] = f_alu(1, 0, 1, 0, 3);
        rom[7'h28] = f_lit(32'h100);    rom[7'h29] = f_alu(12, 0, 0, 0, 0);
        rom[7'h30] = f_lit(32'h0FFF_FFFE); rom[7'h31] = f_alu(6, 0, 0, 0, 0);
        rom[7'h32] = f_alu(12, 0, 0, 0, 0);
        rom[7'h38] = f_lit(32'hA5);     rom[7'h39] = f_lit(32'h0FFF_FFFD);
        rom[7'h3A] = f_alu(6, 0, 0, 0, 0); rom[7'h3B] = f_alu(1, 0, 1, 0, 3);
        rom[7'h40] = f_call(32'h48);
        rom[7'h48] = f_lit(0);          rom[7'h49] = f_zbr(32'h4B);
        rom[7'h4A] = f_lit(9);          rom[7'h4B] = f_alu(0, 1, 0, 3, 0);
        rom[7'h50] = f_lit(1); rom[7'h51] = f_lit(2); rom[7'h52] = f_lit(3); rom[7'h53] = f_lit(4);
        rom[7'h58] = f_alu(0, 1, 0, 3, 0);
        rom[7'h5C] = f_alu(0, 0, 0, 3, 3);

        rst = 1'b1; start_i = 1'b0; halt_i = 1'b0; start_adr_i = '0; io_dat_i = 8'h5A;
        step(2);
        check("rst_running", 32'(running_o), 0);
        check("rst_inst_cyc", 32'(inst_cyc_o), 0);
        check("rst_cyc", 32'(cyc_o), 0);
        check("rst_fault", 32'(fault_o), 0);
        check("rst_adr", adr_o, 0);
        check("rst_tos", dut.tos, 0);
        check("cpu_num", 32'(cpu_num), 3);
        rst = 1'b0;
        step(3);
        check("idle_no_fetch", 32'(inst_cyc_o), 0);

        // lit 5, lit 7, + : one instruction every 2 cycles
        start_at(14'h010);
        check("start_pc", 32'(inst_pc_o), 32'h10);
        check("start_running", 32'(running_o), 1);
        check("start_fault", 32'(fault_o), 0);
        step(4);
        check("add_mid_tos", dut.tos, 7);
        check("add_mid_dsp", 32'(dut.dsp), 2);
        step(2);
        check("add_pc", 32'(inst_pc_o), 32'h13);
        check("add_tos", dut.tos, 12);
        check("add_dsp", 32'(dut.dsp), 1);
        halt_to_idle("halt_after_add");
        check("halt_inst_cyc", 32'(inst_cyc_o), 0);

        // store 0x1234 to 0x100 with 3 wait states
        start_at(14'h020);
        step(5);
        check("st_pre_cyc", 32'(cyc_o), 0);
        nhi = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (cyc_o) nhi++;
            if (i == 0) begin
                check("st_we", 32'(we_o), 1);
                check("st_adr", adr_o, 32'h100);
                check("st_dat", dat_o, 32'h1234);
                check("st_no_fetch", 32'(inst_cyc_o), 0);
            end
            if (i == 2) check("st_pc_hold", 32'(inst_pc_o), 32'h22);
        end
        check("st_cyc_len", nhi, 4);
        check("st_pc_after", 32'(inst_pc_o), 32'h23);
        check("st_tos", dut.tos, 32'h1234);
        check("st_mem", dmem[0], 32'h1234);
        halt_to_idle("halt_after_st");

        // load with halt raised during the wait
        start_at(14'h028);
        step(5);
        halt_i = 1'b1;
        step(2);
        check("ld_halt_cyc_held", 32'(cyc_o), 1);
        step(1);
        halt_i = 1'b0;
        check("ld_halt_idle", 32'(running_o), 0);
        check("ld_halt_no_fetch", 32'(inst_cyc_o), 0);
        check("ld_halt_cyc_drop", 32'(cyc_o), 0);
        check("ld_tos", dut.tos, 32'h1234);

        // IO read from 0xF0000001
        start_at(14'h030);
        nrd = 0; ncyc = 0;
        for (int i = 1; i <= 8; i++) begin
            step(1);
            if (io_rd_o) nrd++;
            if (cyc_o) ncyc++;
            if (i == 5) begin
                check("io_rd_strobe", 32'(io_rd_o), 1);
                check("io_rd_adr", 32'(io_adr_o), 1);
            end
            if (i == 6) check("io_rd_tos", dut.tos, 32'h5A);
        end
        check("io_rd_pulses", nrd, 1);
        check("io_rd_no_cyc", ncyc, 0);
        halt_to_idle("halt_after_iord");

        // IO write of 0xA5 to 0xF0000002
        start_at(14'h038);
        step(7);
        check("io_wr_strobe", 32'(io_wr_o), 1);
        check("io_wr_adr", 32'(io_adr_o), 2);
        check("io_wr_dat", 32'(io_dat_o), 32'hA5);
        check("io_wr_no_cyc", 32'(cyc_o), 0);
        step(1);
        check("io_wr_strobe_off", 32'(io_wr_o), 0);
        check("io_wr_tos", dut.tos, 32'hA5);
        check("io_wr_dsp", 32'(dut.dsp), 1);
        halt_to_idle("halt_after_iowr");

        // call, taken 0branch, return
        start_at(14'h040);
        step(2);
        check("call_pc", 32'(inst_pc_o), 32'h48);
        check("call_rsp", 32'(dut.rsp), 1);
        step(4);
        check("zbr_taken_pc", 32'(inst_pc_o), 32'h4B);
        check("zbr_tos", dut.tos, 32'hA5);
        step(2);
        check("ret_pc", 32'(inst_pc_o), 32'h41);
        check("ret_rsp", 32'(dut.rsp), 0);
        check("ret_dsp", 32'(dut.dsp), 0);
        halt_to_idle("halt_after_ret");

        // data stack overflow on the 4th literal
        start_at(14'h050);
        step(8);
        check("dovf_fault", 32'(fault_o), 1);
        check("dovf_running", 32'(running_o), 0);
        check("dovf_dsp", 32'(dut.dsp), 3);
        check("dovf_tos", dut.tos, 3);
        step(2);
        check("dovf_stays", 32'(inst_cyc_o), 0);

        // start with halt together: start wins, clears fault
        halt_i = 1'b1;
        start_at(14'h058);
        halt_i = 1'b0;
        check("fault_cleared", 32'(fault_o), 0);
        check("restart_running", 32'(running_o), 1);
        check("restart_pc", 32'(inst_pc_o), 32'h58);
        step(2);
        check("rund_fault", 32'(fault_o), 2);
        start_at(14'h05C);
        step(2);
        check("both_fault", 32'(fault_o), 3);

        // reset in the middle of a memory wait
        start_at(14'h028);
        step(5);
        check("rstmid_cyc_before", 32'(cyc_o), 1);
        rst = 1'b1;
        step(1);
        check("rstmid_cyc", 32'(cyc_o), 0);
        check("rstmid_running", 32'(running_o), 0);
        check("rstmid_fault", 32'(fault_o), 0);
        rst = 1'b0;
        step(3);
        check("rstmid_stays_idle", 32'(running_o), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
